udp_payload_strip: RTL
======================

// Module: udp_payload_strip
// PURPOSE
// Strips the 20B IPv4 header and the 8B UDP header from an IPv4 AXI stream and realigns the
// UDP payload (MoldUDP64 packet) to byte lane 0. Feeds the moldudp64 udp_axis_* input directly.
// Filters on version/IHL, protocol and destination port. Counts dropped and forwarded packets.
// PARAMETERS
// AXI_DATA_W  64        stream width; only 64 supported
// AXI_KEEP_W  8         AXI_DATA_W/8
// DST_PORT    16'd5000  accepted UDP destination port
// PORT_FILT   1         1: drop port mismatch; 0: accept any port
// CNT_W       16        width of the statistics counters
// PORTS
// clk             in   1   clock
// nreset          in   1   synchronous reset, active-high
// ip_tvalid_i     in   1   input beat valid; byte 0 of the IPv4 header is in tdata[7:0] of the first beat
// ip_tkeep_i      in   8   byte enables; all ones except on the tlast beat (contiguous from lane 0)
// ip_tdata_i      in   64  IPv4 packet bytes, little-endian lanes
// ip_tlast_i      in   1   last beat of the packet
// ip_tuser_i      in   1   packet error flag; sampled on the tlast beat
// ip_tready_o     out  1   input accept
// udp_tvalid_o    out  1   payload beat valid
// udp_tkeep_o     out  8   payload byte enables
// udp_tdata_o     out  64  payload data; payload byte 0 is in lane 0
// udp_tlast_o     out  1   last payload beat
// udp_tuser_o     out  1   error flag, valid with tlast
// udp_tready_i    in   1   downstream accept
// drop_cnt_o      out  CNT_W  packets dropped (saturating)
// fwd_cnt_o       out  CNT_W  packets forwarded (saturating)
// BEHAVIOUR
// - Input handshake: a beat transfers when ip_tvalid_i & ip_tready_o.
// - ip_tready_o = (~udp_tvalid_o | udp_tready_i) & (state != FLUSH).
// - Output register: loads when udp_tready_i is high or udp_tvalid_o is low. Data is held stable while stalled.
// - Reset values: state=H0, udp_tvalid_o=0, udp_tlast_o=0, udp_tuser_o=0, udp_tkeep_o=0, both counters=0, hi_q=0.
//   udp_tdata_o resets to 0.
// - FSM states: H0, H1, H2, H3, PAY, FLUSH, DROP. Each state transition happens on an accepted beat.
//   The exception is FLUSH, which transitions on output acceptance.
//   - H0: byte0 != 8'h45 -> DROP; otherwise -> H1.
//   - H1: byte9 (lane 1) != 8'h11 -> DROP; otherwise -> H2.
//   - H2: if PORT_FILT and dst port {lane6,lane7} (big-endian, lane 6 is the MSB) != DST_PORT -> DROP;
//     otherwise -> H3.
//   - H3: lanes 0-3 are UDP len/csum and are discarded. Store lanes 4-7 in hi_q; -> PAY.
//     If tlast is set on this beat with keep[7:4]==0, the payload is empty: drop, no output, -> H0.
//     If tlast is set with keep[7:4]!=0, emit one beat {32'h0,data[63:32]}, keep {4'h0,keep[7:4]}, last=1 -> H0.
//   - PAY: emit {data[31:0],hi_q}, keep {keep[3:0],4'hF}, then set hi_q <= data[63:32].
//     - On tlast with keep[7:4]==0: that emitted beat has last=1 -> H0.
//     - On tlast with keep[7:4]!=0: the emitted beat has last=0 -> FLUSH.
//   - FLUSH: emit {32'h0,hi_q}, keep {4'h0,keep_q[7:4]}, last=1 -> H0.
//   - DROP: consume beats with no output until tlast -> H0.
// - tlast seen in H0/H1/H2 (truncated header): no output, count as a drop, -> H0.
//   A tlast beat that is itself rejected by the H0/H1/H2 checks: no output, one drop, -> H0.
// - udp_tuser_o = registered ip_tuser_i of the packet's tlast beat, driven with udp_tlast_o.
//   In FLUSH it comes from tuser_q.
// - drop_cnt_o increments once per dropped packet, at the transition into H0.
//   fwd_cnt_o increments once per packet when its last beat is accepted downstream.
//   Both counters saturate at all ones.
// - Latency: first payload beat appears 1 cycle after the H3+1 input beat (or after H3 for a <=4B payload).
//   Throughput is 1 beat/cycle, plus one extra cycle per packet that needs FLUSH.
// - Reset asserted mid-packet returns to H0 and discards the rest. The next beat after reset is treated as header 0.
// TESTING
// - IP 0x45, proto 0x11, port 5000, 20B payload 0x00..0x13 -> 3 out beats. Beats 1-2 keep 0xFF, last beat keep 0x0F.
//   Bytes arrive in order, tlast only on the 3rd beat, fwd_cnt=1.
// - Same packet with dst port 5001 -> no udp_tvalid_o, drop_cnt=1.
//   With PORT_FILT=0 the packet is forwarded.
// - 8B UDP payload: input ends with keep 0x0F on the beat after H3 -> single out beat keep 0xFF, last=1, no FLUSH cycle.
// - Proto 0x06 (TCP), then a valid packet back-to-back -> first packet dropped, second forwarded intact.
//   drop_cnt=1, fwd_cnt=1.
// - udp_tready_i toggled 1010... during a 40B payload with tuser=1 on the tlast beat -> output data is unchanged
//   while stalled, no beat is lost or duplicated, udp_tuser_o=1 on the last beat.
// - Reset pulsed during PAY of packet A, then packet B sent -> B output is correct with no residue from A.

Source files
------------

// File: rtl/udp_payload_strip_if.sv
// -----------------------------------------------------------------------------
// udp_payload_strip_if
// Purpose : AXI4-Stream style bundle used for both the IPv4 input stream and
//           the realigned UDP payload output stream of udp_payload_strip.
// Signals : tvalid  beat valid (source)
//           tready  beat accept (sink)
//           tdata   DATA_W bits of data, little-endian byte lanes
//           tkeep   KEEP_W byte enables, contiguous from lane 0
//           tlast   last beat of the packet
//           tuser   packet error flag, meaningful on the tlast beat
// Modports: master drives the stream, slave accepts it.
// -----------------------------------------------------------------------------
interface udp_payload_strip_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/udp_payload_strip.sv
// -----------------------------------------------------------------------------
// udp_payload_strip
// Purpose : Removes the 20-byte IPv4 header and 8-byte UDP header from a 64-bit
//           IPv4 stream and realigns the UDP payload so that payload byte 0
//           sits in lane 0. Packets with a bad version/IHL, a non-UDP protocol,
//           a wrong destination port (optional) or an empty/truncated payload
//           are consumed silently. Dropped and forwarded packets are counted.
// Ports   : clk         clock
//           nreset      synchronous reset, active-high
//           ip_i        input stream (slave), IPv4 byte 0 in lane 0 of beat 0
//           udp_o       output stream (master), payload realigned to lane 0
//           drop_cnt_o  saturating count of dropped packets
//           fwd_cnt_o   saturating count of packets fully accepted downstream
// Only a 64-bit stream is supported.
// -----------------------------------------------------------------------------
module udp_payload_strip #(
  parameter int          AXI_DATA_W = 64,
  parameter int          AXI_KEEP_W = AXI_DATA_W / 8,
  parameter logic [15:0] DST_PORT   = 16'd5000,
  parameter bit          PORT_FILT  = 1'b1,
  parameter int          CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       nreset,
  udp_payload_strip_if.slave         ip_i,
  udp_payload_strip_if.master        udp_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic [CNT_W-1:0]           fwd_cnt_o
);

  typedef enum logic [2:0] {H0, H1, H2, H3, PAY, FLUSH, DROP} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             hi_q, hi_d;           // upper half of the previous beat
  logic [3:0]              keep_hi_q, keep_hi_d; // tkeep[7:4] of the tlast beat
  logic                    tuser_q, tuser_d;     // tuser of the tlast beat

  logic                    out_valid_q;
  logic [AXI_DATA_W-1:0]   out_data_q;
  logic [AXI_KEEP_W-1:0]   out_keep_q;
  logic                    out_last_q;
  logic                    out_user_q;
  logic [CNT_W-1:0]        drop_cnt_q;
  logic [CNT_W-1:0]        fwd_cnt_q;

  logic                    emit;
  logic [AXI_DATA_W-1:0]   emit_data;
  logic [AXI_KEEP_W-1:0]   emit_keep;
  logic                    emit_last;
  logic                    emit_user;
  logic                    drop_pkt;

  logic                    out_load;
  logic                    in_ready;
  logic                    in_fire;
  logic                    tail_hi;
  logic                    fwd_fire;
  logic [15:0]             dst_port;

  // The output register may take a new beat whenever it is empty or being
  // drained; input is blocked while the FLUSH beat waits for that slot.
  assign out_load = udp_o.tready | ~out_valid_q;
  assign in_ready = out_load & (state_q != FLUSH);
  assign in_fire  = ip_i.tvalid & in_ready;
  assign tail_hi  = |ip_i.tkeep[7:4];
  assign dst_port = {ip_i.tdata[55:48], ip_i.tdata[63:56]};
  assign fwd_fire = out_valid_q & udp_o.tready & out_last_q;

  assign ip_i.tready  = in_ready;
  assign udp_o.tvalid = out_valid_q;
  assign udp_o.tdata  = out_data_q;
  assign udp_o.tkeep  = out_keep_q;
  assign udp_o.tlast  = out_last_q;
  assign udp_o.tuser  = out_user_q;
  assign drop_cnt_o   = drop_cnt_q;
  assign fwd_cnt_o    = fwd_cnt_q;

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    keep_hi_d = keep_hi_q;
    tuser_d   = tuser_q;
    emit      = 1'b0;
    emit_data = '0;
    emit_keep = '0;
    emit_last = 1'b0;
    emit_user = 1'b0;
    drop_pkt  = 1'b0;

    case (state_q)
      // Header beats: a tlast here means the header is truncated, which is
      // a drop no matter what the checks say.
      H0: if (in_fire) begin
        if (ip_i.tlast) begin
          drop_pkt = 1'b1;
          state_d  = H0;
        end else if (ip_i.tdata[7:0] != 8'h45) begin
          state_d = DROP;
        end else begin
          state_d = H1;
        end
      end
      H1: if (in_fire) begin
        if (ip_i.tlast) begin
          drop_pkt = 1'b1;
          state_d  = H0;
        end else if (ip_i.tdata[15:8] != 8'h11) begin
          state_d = DROP;
        end else begin
          state_d = H2;
        end
      end
      H2: if (in_fire) begin
        if (ip_i.tlast) begin
          drop_pkt = 1'b1;
          state_d  = H0;
        end else if (PORT_FILT && (dst_port != DST_PORT)) begin
          state_d = DROP;
        end else begin
          state_d = H3;
        end
      end
      // Lanes 0-3 are UDP length/checksum; lanes 4-7 start the payload.
      H3: if (in_fire) begin
        hi_d = ip_i.tdata[63:32];
        if (ip_i.tlast) begin
          state_d = H0;
          if (!tail_hi) begin
            drop_pkt = 1'b1;
          end else begin
            emit      = 1'b1;
            emit_data = {32'h0, ip_i.tdata[63:32]};
            emit_keep = {4'h0, ip_i.tkeep[7:4]};
            emit_last = 1'b1;
            emit_user = ip_i.tuser;
          end
        end else begin
          state_d = PAY;
        end
      end
      PAY: if (in_fire) begin
        emit      = 1'b1;
        emit_data = {ip_i.tdata[31:0], hi_q};
        emit_keep = {ip_i.tkeep[3:0], 4'hF};
        hi_d      = ip_i.tdata[63:32];
        if (ip_i.tlast) begin
          if (!tail_hi) begin
            emit_last = 1'b1;
            emit_user = ip_i.tuser;
            state_d   = H0;
          end else begin
            // Upper half of the final beat still has to go out on its own.
            keep_hi_d = ip_i.tkeep[7:4];
            tuser_d   = ip_i.tuser;
            state_d   = FLUSH;
          end
        end
      end
      FLUSH: if (out_load) begin
        emit      = 1'b1;
        emit_data = {32'h0, hi_q};
        emit_keep = {4'h0, keep_hi_q};
        emit_last = 1'b1;
        emit_user = tuser_q;
        state_d   = H0;
      end
      DROP: if (in_fire && ip_i.tlast) begin
        drop_pkt = 1'b1;
        state_d  = H0;
      end
      default: state_d = H0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      state_q     <= H0;
      hi_q        <= '0;
      keep_hi_q   <= '0;
      tuser_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      drop_cnt_q  <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      keep_hi_q <= keep_hi_d;
      tuser_q   <= tuser_d;
      if (out_load) begin
        out_valid_q <= emit;
        out_data_q  <= emit_data;
        out_keep_q  <= emit_keep;
        out_last_q  <= emit_last;
        out_user_q  <= emit_user;
      end
      if (drop_pkt && (drop_cnt_q != {CNT_W{1'b1}})) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
      if (fwd_fire && (fwd_cnt_q != {CNT_W{1'b1}})) begin
        fwd_cnt_q <= fwd_cnt_q + 1'b1;
      end
    end
  end

endmodule
